// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
//   Shares one single-port block RAM between two requesters (A and B) with
//   round-robin arbitration, one access per cycle. Drives the RAM primitive
//   directly and returns tagged read data after RD_LATENCY clocks.
//
// Optional feature (define SP_RAM_ARB_CLEAR_EN): after reset the whole RAM is
//   swept with zeros (one write per cycle, 2**ADDR_W cycles) before any
//   requester is served; clr_busy is high during the sweep.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   a_* / b_*             valid/ready request channel (we, addr, wdata) and
//                         read return (rvalid, rdata) for requesters A and B
//   ram_ce, ram_oce,      RAM primitive controls (ram_oce tied high,
//   ram_wre, ram_reset    ram_reset = !rst_n)
//   ram_ad, ram_din       RAM address / write data
//   ram_dout              RAM read data
//   clr_busy              zero-fill sweep in progress
module sp_ram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              clr_busy
);

    typedef struct packed {
        logic vld;
        logic id;  // 0 = A, 1 = B
    } tag_t;

    logic              run;     // requesters may be served
    logic              clr_we;  // sweep write this cycle
    logic [ADDR_W-1:0] clr_ad;

`ifdef SP_RAM_ARB_CLEAR_EN
    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run      = (state_q == StRun);
    assign clr_we   = (state_q == StClear) && rst_n;
    assign clr_ad   = cnt_q;
    assign clr_busy = (state_q == StClear);
`else
    assign run      = 1'b1;
    assign clr_we   = 1'b0;
    assign clr_ad   = '0;
    assign clr_busy = 1'b0;
`endif

    logic                  ptr_q, ptr_d;  // 0 = A has priority on contention
    logic                  grant_a, grant_b;
    tag_t [RD_LATENCY-1:0] tag_q, tag_d;
    tag_t                  tag_out;
    logic [ADDR_W-1:0]     ad_q, ad_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [DATA_W-1:0]     a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]     b_rdata_q, b_rdata_d;

    // No accepts while reset is held, so nothing reaches the RAM in reset.
    assign grant_a = rst_n && run && a_valid && (!b_valid || !ptr_q);
    assign grant_b = rst_n && run && b_valid && (!a_valid || ptr_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign ram_oce   = 1'b1;
    assign ram_reset = !rst_n;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_a) begin
            ptr_d = 1'b1;
        end else if (grant_b) begin
            ptr_d = 1'b0;
        end
    end

    // Address/data hold their last value when idle to avoid needless toggling.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = ad_q;
        ram_din = din_q;
        if (clr_we) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = clr_ad;
            ram_din = '0;
        end else if (grant_a) begin
            ram_ce  = 1'b1;
            ram_wre = a_we;
            ram_ad  = a_addr;
            ram_din = a_wdata;
        end else if (grant_b) begin
            ram_ce  = 1'b1;
            ram_wre = b_we;
            ram_ad  = b_addr;
            ram_din = b_wdata;
        end
        ad_d  = ram_ad;
        din_d = ram_din;
    end

    // Read tags travel alongside the RAM read latency.
    always_comb begin
        tag_d        = '0;
        tag_d[0].vld = (grant_a && !a_we) || (grant_b && !b_we);
        tag_d[0].id  = grant_b;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out = tag_q[RD_LATENCY-1];

    // rvalid is masked by rst_n so a read caught by reset never returns.
    always_comb begin
        a_rvalid  = tag_out.vld && !tag_out.id && rst_n;
        b_rvalid  = tag_out.vld && tag_out.id && rst_n;
        a_rdata_d = a_rvalid ? ram_dout : a_rdata_q;
        b_rdata_d = b_rvalid ? ram_dout : b_rdata_q;
        a_rdata   = a_rdata_d;
        b_rdata   = b_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= 1'b0;
            tag_q     <= '0;
            ad_q      <= '0;
            din_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            tag_q     <= tag_d;
            ad_q      <= ad_d;
            din_q     <= din_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter (default parameters, RD_LATENCY = 1).
// A behavioural 1024x16 single-port RAM sits on the RAM-side ports.
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_we, a_rvalid;
    logic [9:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rvalid;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic        ram_ce, ram_oce, ram_wre, ram_reset;
    logic [9:0]  ram_ad;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        clr_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int unexp_rv = 0;
    logic mon_a  = 1'b0;

    logic [15:0] mem [1024];

    always #5 clk = ~clk;

    sp_ram_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (16),
        .RD_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_reset (ram_reset),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .clr_busy  (clr_busy)
    );

    // Bypass-mode single-port RAM: read data valid one clock after the access.
    always @(posedge clk) begin
        if (ram_reset) begin
            ram_dout <= 16'h0;
        end else if (ram_ce && !ram_wre) begin
            ram_dout <= mem[ram_ad];
        end
        if (ram_ce && ram_wre) begin
            mem[ram_ad] <= ram_din;
        end
    end

    always @(negedge clk) begin
        #1;
        if (mon_a && a_rvalid) unexp_rv++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Releases reset on a falling edge; with the sweep built in, follows it to the end.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef SP_RAM_ARB_CLEAR_EN
        begin
            int n    = 0;
            int errs = 0;
            while (clr_busy && n < 2000) begin
                if (ram_ad != 10'(n) || ram_din != 16'h0 || !ram_ce || !ram_wre ||
                    a_ready || b_ready) errs++;
                @(negedge clk);
                #1;
                n++;
            end
            check("clr_len", 32'(n), 32'd1024);
            check("clr_sweep", 32'(errs), 32'd0);
        end
`else
        check("clr_busy_off", 32'(clr_busy), 32'd0);
`endif
        check("ram_reset_rel", 32'(ram_reset), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        release_reset();
    endtask

    // A takes even addresses 0,2,4 and B odd 1,3,5, both contending each cycle.
    task automatic run_pair(input logic we);
        int   ai = 0;
        int   bi = 0;
        logic prev_a = 1'b0;
        int   prev_addr = 0;
        logic exp_a;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            a_valid = (ai < 3);
            a_we    = we;
            a_addr  = 10'(2 * ai);
            a_wdata = 16'(32'h1000 + 2 * ai);
            b_valid = (bi < 3);
            b_we    = we;
            b_addr  = 10'(2 * bi + 1);
            b_wdata = 16'(32'h1000 + 2 * bi + 1);
            #1;
            if (k > 0) begin
                if (we) begin
                    check("wr_no_rvalid", 32'(a_rvalid | b_rvalid), 32'd0);
                end else if (prev_a) begin
                    check("rr_a_rvalid", 32'(a_rvalid), 32'd1);
                    check("rr_a_rdata", 32'(a_rdata), 32'h1000 + 32'(prev_addr));
                    check("rr_b_quiet", 32'(b_rvalid), 32'd0);
                end else begin
                    check("rr_b_rvalid", 32'(b_rvalid), 32'd1);
                    check("rr_b_rdata", 32'(b_rdata), 32'h1000 + 32'(prev_addr));
                    check("rr_a_quiet", 32'(a_rvalid), 32'd0);
                end
            end
            if (k < 6) begin
                exp_a     = (k % 2 == 0);
                prev_a    = exp_a;
                prev_addr = exp_a ? 2 * ai : 2 * bi + 1;
                check("rr_a_ready", 32'(a_ready), 32'(exp_a));
                check("rr_b_ready", 32'(b_ready), 32'(!exp_a));
                check("rr_ram_ad", 32'(ram_ad), 32'(prev_addr));
                check("rr_ram_wre", 32'(ram_wre), 32'(we));
                if (exp_a) ai++;
                else bi++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] av, bv, ea, eb;

        rst_n   = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rdata", 32'(b_rdata), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        check("rst_ram_reset", 32'(ram_reset), 32'd1);
        check("ram_oce", 32'(ram_oce), 32'd1);
`ifdef SP_RAM_ARB_CLEAR_EN
        check("rst_clr_busy", 32'(clr_busy), 32'd1);
`endif
        release_reset();
        check("idle_ram_ce", 32'(ram_ce), 32'd0);
        check("idle_a_ready", 32'(a_ready), 32'd0);

        // A writes 0xBEEF at 0x155, B reads it back the next cycle
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h155; a_wdata = 16'hBEEF;
        #1;
        check("raw_a_ready", 32'(a_ready), 32'd1);
        check("raw_ce", 32'(ram_ce), 32'd1);
        check("raw_wre", 32'(ram_wre), 32'd1);
        check("raw_ad", 32'(ram_ad), 32'h155);
        check("raw_din", 32'(ram_din), 32'hBEEF);
        @(negedge clk);
        a_valid = 1'b0; a_we = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 10'h155;
        #1;
        check("raw_b_ready", 32'(b_ready), 32'd1);
        check("raw_rd_wre", 32'(ram_wre), 32'd0);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        check("raw_b_rvalid", 32'(b_rvalid), 32'd1);
        check("raw_b_rdata", 32'(b_rdata), 32'hBEEF);
        check("raw_a_rvalid", 32'(a_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("raw_rvalid_pulse", 32'(b_rvalid), 32'd0);
        check("raw_rdata_hold", 32'(b_rdata), 32'hBEEF);
        check("idle_ce", 32'(ram_ce), 32'd0);
        check("idle_ad_hold", 32'(ram_ad), 32'h155);

        // Read from A caught by reset: never returns, pointer goes back to A
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h155;
        #1;
        check("rstrd_a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        mon_a   = 1'b1;
        apply_reset();
        repeat (3) @(negedge clk);
        #2;
        mon_a = 1'b0;
        check("rstrd_no_rvalid", 32'(unexp_rv), 32'd0);

        // Contended writes preload 0..5, then contended reads return them in order
        run_pair(1'b1);
        run_pair(1'b0);

        // A holds valid, B asserts once: B served within one cycle
        av = 4'b1111; bv = 4'b0011; ea = 4'b1101; eb = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_valid = av[c]; a_we = 1'b0; a_addr = 10'h000;
            b_valid = bv[c]; b_we = 1'b0; b_addr = 10'h005;
            #1;
            check("starve_a_ready", 32'(a_ready), 32'(ea[c]));
            check("starve_b_ready", 32'(b_ready), 32'(eb[c]));
            if (c == 2) begin
                check("starve_b_rvalid", 32'(b_rvalid), 32'd1);
                check("starve_b_rdata", 32'(b_rdata), 32'h1005);
            end
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;

`ifdef SP_RAM_ARB_CLEAR_EN
        // Sweep erases 0x3FF; a request held through the sweep is served after it
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_wdata = 16'h1234;
        #1;
        check("clr_wr_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_we = 1'b0;
        apply_reset();
        check("clr_served", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("clr_rvalid", 32'(a_rvalid), 32'd1);
        check("clr_rdata", 32'(a_rdata), 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
